// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that holds the architectural HI/LO
// registers. It runs MULT, MULTU, DIV and DIVU over 33 cycles: one cycle per
// operand bit (RUN), then one sign-fix cycle (FIX). It also services MTHI/MTLO
// writes while idle.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous active-high reset
//   i_start    launch operation (sampled only in IDLE)
//   i_op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_a, i_b   rs / rt operands
//   i_mthi     write i_wdata to HI (IDLE only)
//   i_mtlo     write i_wdata to LO (IDLE only)
//   i_wdata    MTHI/MTLO data
//   o_hi, o_lo HI/LO registers
//   o_busy     operation in progress
//   o_done     one-cycle pulse when HI/LO take a result
//   o_divzero  valid with o_done: the completed divide had b == 0
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mthi,
   input  logic             i_mtlo,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_divzero
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_is_div;
   logic             r_neg_q;      // product / quotient sign
   logic             r_neg_r;      // remainder sign
   logic             r_bzero;
   logic [5:0]       r_cnt;
   logic [WIDTH-1:0] r_opnd;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0] r_a_orig;     // original dividend, returned in HI on divide-by-zero
   logic [W2-1:0]    r_acc;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_divzero;

   logic             w_accept;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_divzero_nxt;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;

   logic [WIDTH:0]   w_addend;
   logic [WIDTH:0]   w_mul_sum;
   logic [W2-1:0]    w_mul_acc;
   logic [WIDTH+1:0] w_div_diff;
   logic [W2-1:0]    w_div_acc;

   logic [W2-1:0]    w_prod;
   logic [WIDTH-1:0] w_q_raw;
   logic [WIDTH-1:0] w_r_raw;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == 6'(WIDTH - 1)) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (registered below) ----------------
   always_comb begin
      w_accept      = (r_state == S_IDLE) && i_start;
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_done_nxt    = (r_state == S_FIX);
      w_divzero_nxt = (r_state == S_FIX) && r_is_div && r_bzero;
   end

   // ---------------- operand conditioning ----------------
   always_comb begin
      w_a_neg = ~i_op[0] & i_a[WIDTH-1];
      w_b_neg = ~i_op[0] & i_b[WIDTH-1];
      w_mag_a = w_a_neg ? (~i_a + 1'b1) : i_a;
      w_mag_b = w_b_neg ? (~i_b + 1'b1) : i_b;
   end

   // ---------------- iteration datapath ----------------
   always_comb begin
      // shift-add: acc low half holds the not-yet-consumed multiplier bits
      w_addend  = r_acc[0] ? {1'b0, r_opnd} : '0;
      w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + w_addend;
      w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

      // restoring divide: the upper 33 bits after a 1-bit left shift are r_acc[W2-1:WIDTH-1]
      w_div_diff = {1'b0, r_acc[W2-1:WIDTH-1]} - {2'b00, r_opnd};
      if (w_div_diff[WIDTH+1])
         w_div_acc = {r_acc[W2-2:0], 1'b0};
      else
         w_div_acc = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
   end

   // ---------------- sign fix ----------------
   always_comb begin
      w_prod  = r_neg_q ? (~r_acc + 1'b1) : r_acc;
      w_q_raw = r_acc[WIDTH-1:0];
      w_r_raw = r_acc[W2-1:WIDTH];
      w_quo   = r_neg_q ? (~w_q_raw + 1'b1) : w_q_raw;
      w_rem   = r_neg_r ? (~w_r_raw + 1'b1) : w_r_raw;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_bzero  <= 1'b0;
         r_cnt    <= '0;
         r_opnd   <= '0;
         r_a_orig <= '0;
         r_acc    <= '0;
      end else if (w_accept) begin
         r_is_div <= i_op[1];
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_bzero  <= (i_b == '0);
         r_cnt    <= '0;
         r_a_orig <= i_a;
         if (i_op[1]) begin
            r_opnd <= w_mag_b;
            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
         end else begin
            r_opnd <= w_mag_a;
            r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
         end
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 6'd1;
         r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end
   end

   // ---------------- architectural HI/LO and status outputs ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_divzero <= 1'b0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_divzero <= w_divzero_nxt;
         if (r_state == S_FIX) begin
            if (r_is_div && r_bzero) begin
               r_hi <= r_a_orig;
               r_lo <= '1;
            end else if (r_is_div) begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end else begin
               r_hi <= w_prod[W2-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end
         end else if (r_state == S_IDLE) begin
            // a write alongside i_start still lands; the result overwrites it later
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
         end
      end
   end

   assign o_hi      = r_hi;
   assign o_lo      = r_lo;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_divzero = r_divzero;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic [1:0]  i_op = 2'b00;
   logic [31:0] i_a = '0;
   logic [31:0] i_b = '0;
   logic        i_mthi = 1'b0;
   logic        i_mtlo = 1'b0;
   logic [31:0] i_wdata = '0;
   logic [31:0] o_hi;
   logic [31:0] o_lo;
   logic        o_busy;
   logic        o_done;
   logic        o_divzero;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [64:0] sb[$];          // {divzero, hi, lo}
   logic [64:0] mon_e;
   logic [31:0] m_hi = '0;      // bench model of architectural HI/LO
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .i_op      (i_op),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_mthi    (i_mthi),
      .i_mtlo    (i_mtlo),
      .i_wdata   (i_wdata),
      .o_hi      (o_hi),
      .o_lo      (o_lo),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_divzero (o_divzero)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected result.
   always @(negedge clk) begin
      if (o_done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done with hi=%h lo=%h expected no pending op", o_hi, o_lo);
         end else begin
            mon_e = sb.pop_front();
            chk("res_hi", 64'(o_hi), 64'(mon_e[63:32]));
            chk("res_lo", 64'(o_lo), 64'(mon_e[31:0]));
            chk("res_divzero", 64'(o_divzero), 64'(mon_e[64]));
            m_hi = mon_e[63:32];
            m_lo = mon_e[31:0];
         end
      end
   end

   // Call at a negedge; returns at the negedge where done is seen.
   task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input logic mthi_at_start, input logic mtlo_mid);
      int busy_n;
      logic seen;
      i_op = op; i_a = a; i_b = b; i_start = 1'b1;
      if (mthi_at_start) begin i_mthi = 1'b1; i_wdata = 32'h0000CAFE; end
      sb.push_back({edz, eh, el});
      @(posedge clk); #1;
      i_start = 1'b0;
      if (mthi_at_start) begin
         i_mthi = 1'b0;
         m_hi = 32'h0000CAFE;
         chk({nm, "_mthi_with_start"}, 64'(o_hi), 64'(m_hi));
      end
      busy_n = 0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mtlo_mid && c == 5) begin i_mtlo = 1'b1; i_wdata = 32'h0000DEAD; end
         if (c == 6) i_mtlo = 1'b0;
         if (c == 16) begin
            chk({nm, "_hi_stable"}, 64'(o_hi), 64'(m_hi));
            chk({nm, "_lo_stable"}, 64'(o_lo), 64'(m_lo));
         end
         if (o_busy) busy_n++;
         if (o_done) begin seen = 1'b1; break; end
      end
      chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd33);
      chk({nm, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   initial begin
      int cnt;
      logic seen;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);
      chk("rst_hi", 64'(o_hi), 64'd0);
      chk("rst_lo", 64'(o_lo), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_divzero", 64'(o_divzero), 64'd0);

      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("done_single_pulse", 64'(o_done), 64'd0);
      chk("busy_after_done", 64'(o_busy), 64'd0);

      run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      run_op("multu_same", 2'b01, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      run_op("div_zero", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      // back-to-back: second start issued in the done cycle of the first
      run_op("divu_16", 2'b11, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0);
      run_op("b2b_mtlo_busy", 2'b01, 32'd6, 32'd7, 32'h00000000, 32'd42, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // MTHI in IDLE
      i_mthi = 1'b1; i_wdata = 32'h00001234;
      @(posedge clk); #1;
      i_mthi = 1'b0;
      @(negedge clk);
      chk("mthi_idle", 64'(o_hi), 64'h1234);
      m_hi = 32'h00001234;

      // MTHI together with start: write lands, then the result overwrites it
      run_op("mult_mthi", 2'b00, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      // a second start while busy is ignored
      i_op = 2'b01; i_a = 32'd3; i_b = 32'd4; i_start = 1'b1;
      sb.push_back({1'b0, 32'd0, 32'd12});
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (9) @(negedge clk);
      i_op = 2'b11; i_a = 32'd50; i_b = 32'd7; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_done) begin seen = 1'b1; break; end
      end
      chk("ignored_start_done_seen", 64'(seen), 64'd1);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_busy) cnt++;
      end
      chk("ignored_start_no_rerun", 64'(cnt), 64'd0);

      // reset aborts an operation in flight
      i_op = 2'b01; i_a = 32'd9; i_b = 32'd9; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (14) @(negedge clk);
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      @(negedge clk);
      chk("abort_hi", 64'(o_hi), 64'd0);
      chk("abort_lo", 64'(o_lo), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_done", 64'(o_done), 64'd0);
      m_hi = '0;
      m_lo = '0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_done || o_busy) cnt++;
      end
      chk("abort_no_activity", 64'(cnt), 64'd0);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
